// File: rtl/bft_gen_pkg.sv
// Shared widths, default config tag and controller states
// for the BFT configuration/data stimulus generator.
package bft_gen_pkg;

    localparam int CFG_W  = 64;
    localparam int DATA_W = 512;
    localparam int LANE_W = 32;
    localparam int LANES  = 16;

    localparam logic [31:0] CFG_TAG_DEF = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        DATA,
        DONE
    } state_t;

endpackage

// File: rtl/axis_seq_src.sv
// Registered AXI-Stream word source: emits COUNT generated words.
// Ports: clk/rst_n, start (load word 0), tready, tvalid/tdata, done (last handshake).
module axis_seq_src
    import bft_gen_pkg::*;
#(
    parameter int          W       = 64,
    parameter int          COUNT   = 8,
    parameter int          CNT_W   = 16,
    parameter bit          IS_DATA = 1'b0,
    parameter logic [31:0] TAG     = 32'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         tready,
    output logic         tvalid,
    output logic [W-1:0] tdata,
    output logic         done
);

    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] nidx;
    logic [W-1:0]     nword;
    logic             last;
    logic             hs;

    assign hs   = tvalid & tready;
    assign last = (idx == CNT_W'(COUNT - 1));
    assign done = hs & last;

    // Index of the word to be presented after this edge.
    assign nidx = start ? '0 : idx + CNT_W'(1);

    generate
        if (IS_DATA) begin : g_data
            always_comb begin
                nword = '0;
                for (int j = 0; j < W / LANE_W; j++) begin
                    nword[j*LANE_W +: LANE_W] =
                        LANE_W'(nidx) * LANE_W'(LANES)
                        + LANE_W'(j);
                end
            end
        end else begin : g_cfg
            assign nword = W'({TAG, 32'(nidx)});
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            idx    <= '0;
        end else if (start) begin
            tvalid <= 1'b1;
            tdata  <= nword;
            idx    <= '0;
        end else if (hs) begin
            if (last) begin
                tvalid <= 1'b0;
                idx    <= '0;
            end else begin
                tdata <= nword;
                idx   <= nidx;
            end
        end
    end

endmodule

// File: rtl/bft_data_gen_config.sv
// ap_ctrl_hs stimulus source: streams config words, then data words.
// Ports: ap_* control, Output_1 (64b config AXIS), Output_2 (512b data AXIS).
module bft_data_gen_config
    import bft_gen_pkg::*;
#(
    parameter int          NUM_CFG  = 8,
    parameter int          NUM_DATA = 1024,
    parameter logic [31:0] CFG_TAG  = CFG_TAG_DEF
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [CFG_W-1:0]  Output_1_TDATA,
    output logic              Output_1_TVALID,
    input  logic              Output_1_TREADY,
    output logic [DATA_W-1:0] Output_2_TDATA,
    output logic              Output_2_TVALID,
    input  logic              Output_2_TREADY
);

    state_t state;
    logic   cfg_start;
    logic   cfg_done;
    logic   data_start;
    logic   data_done;

    // Starting the next stream on the same edge as the last
    // handshake keeps the two streams strictly back to back.
    assign cfg_start  = (state == IDLE) & ap_start;
    assign data_start = (state == CFG) & cfg_done;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= IDLE;
            ap_idle  <= 1'b1;
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ap_start) begin
                        state   <= CFG;
                        ap_idle <= 1'b0;
                    end
                end
                CFG: begin
                    if (cfg_done) state <= DATA;
                end
                DATA: begin
                    if (data_done) begin
                        state    <= DONE;
                        ap_done  <= 1'b1;
                        ap_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    ap_done  <= 1'b0;
                    ap_ready <= 1'b0;
                    ap_idle  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    axis_seq_src #(
        .W       (CFG_W),
        .COUNT   (NUM_CFG),
        .CNT_W   (16),
        .IS_DATA (1'b0),
        .TAG     (CFG_TAG)
    ) u_cfg (
        .clk    (ap_clk),
        .rst_n  (ap_rst_n),
        .start  (cfg_start),
        .tready (Output_1_TREADY),
        .tvalid (Output_1_TVALID),
        .tdata  (Output_1_TDATA),
        .done   (cfg_done)
    );

    axis_seq_src #(
        .W       (DATA_W),
        .COUNT   (NUM_DATA),
        .CNT_W   (24),
        .IS_DATA (1'b1),
        .TAG     (32'h0)
    ) u_data (
        .clk    (ap_clk),
        .rst_n  (ap_rst_n),
        .start  (data_start),
        .tready (Output_2_TREADY),
        .tvalid (Output_2_TVALID),
        .tdata  (Output_2_TDATA),
        .done   (data_done)
    );

endmodule

// File: tb/tb_bft_data_gen_config.sv
// Directed bench for bft_data_gen_config.
// Monitor records handshakes; the initial block checks them.
module tb_bft_data_gen_config;

    localparam int          NC  = 8;
    localparam int          ND  = 1024;
    localparam logic [31:0] TAG = 32'hBFC0_0000;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         r1    = 1'b1;
    logic         r2    = 1'b1;
    logic         ap_done, ap_idle, ap_ready;
    logic [63:0]  d1;
    logic [511:0] d2;
    logic         v1, v2;

    int mode = 0;
    bit clr  = 1'b0;

    logic [63:0]  cfgq[$];
    logic [511:0] dataq[$];
    int           done_cnt = 0;
    int           viol     = 0;
    int           overlap  = 0;
    int           rdy_mis  = 0;
    bit           s1 = 1'b0;
    bit           s2 = 1'b0;
    logic [63:0]  p1 = '0;
    logic [511:0] p2 = '0;

    int checks = 0;
    int errors = 0;

    bft_data_gen_config #(
        .NUM_CFG  (NC),
        .NUM_DATA (ND),
        .CFG_TAG  (TAG)
    ) dut (
        .ap_clk          (clk),
        .ap_rst_n        (rst_n),
        .ap_start        (start),
        .ap_done         (ap_done),
        .ap_idle         (ap_idle),
        .ap_ready        (ap_ready),
        .Output_1_TDATA  (d1),
        .Output_1_TVALID (v1),
        .Output_1_TREADY (r1),
        .Output_2_TDATA  (d2),
        .Output_2_TVALID (v2),
        .Output_2_TREADY (r2)
    );

    always #5 clk = ~clk;

    // Sink ready driver: 0 = always ready, 1 = random, 2 = cfg stalled.
    always @(posedge clk) begin
        #1;
        case (mode)
            1: begin
                r1 <= 1'($urandom_range(0, 1));
                r2 <= 1'($urandom_range(0, 1));
            end
            2: begin
                r1 <= 1'b0;
                r2 <= 1'b1;
            end
            default: begin
                r1 <= 1'b1;
                r2 <= 1'b1;
            end
        endcase
    end

    // Handshakes happen at the next posedge when valid & ready here.
    always @(negedge clk) begin
        if (clr) begin
            cfgq.delete();
            dataq.delete();
            done_cnt <= 0;
            viol     <= 0;
            overlap  <= 0;
            rdy_mis  <= 0;
            s1       <= 1'b0;
            s2       <= 1'b0;
        end else if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            if (s1 && !(v1 && d1 == p1)) viol <= viol + 1;
            if (s2 && !(v2 && d2 == p2)) viol <= viol + 1;
            if (v1 && v2) overlap <= overlap + 1;
            if (ap_done != ap_ready) rdy_mis <= rdy_mis + 1;
            if (ap_done) done_cnt <= done_cnt + 1;
            if (v1 && r1) cfgq.push_back(d1);
            if (v2 && r2) dataq.push_back(d2);
            s1 <= v1 && !r1;
            s2 <= v2 && !r2;
            p1 <= d1;
            p2 <= d2;
        end
    end

    task automatic chk(input string tag,
                       input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] exp_data(input int n);
        logic [511:0] w;
        w = '0;
        for (int j = 0; j < 16; j++)
            w[32*j +: 32] = 32'(16 * n + j);
        return w;
    endfunction

    task automatic verify(input string tag, input int runs);
        logic [63:0] ew;
        chk({tag, "_ncfg"}, 512'(cfgq.size()), 512'(NC * runs));
        chk({tag, "_ndata"}, 512'(dataq.size()), 512'(ND * runs));
        for (int i = 0; i < cfgq.size(); i++) begin
            ew = {TAG, 32'(i % NC)};
            chk($sformatf("%s_cfg%0d", tag, i), 512'(cfgq[i]), 512'(ew));
        end
        for (int i = 0; i < dataq.size(); i++)
            chk($sformatf("%s_dat%0d", tag, i), dataq[i], exp_data(i % ND));
        chk({tag, "_stable"}, 512'(viol), 512'(0));
        chk({tag, "_overlap"}, 512'(overlap), 512'(0));
        chk({tag, "_rdy_eq_done"}, 512'(rdy_mis), 512'(0));
        chk({tag, "_dones"}, 512'(done_cnt), 512'(runs));
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ap_done) break;
        end
    endtask

    initial begin
        int cyc;
        int nd;
        logic [511:0] w1;

        // Reset
        repeat (10) @(negedge clk);
        chk("rst_idle", 512'(ap_idle), 512'(1));
        chk("rst_done", 512'(ap_done), 512'(0));
        chk("rst_ready", 512'(ap_ready), 512'(0));
        chk("rst_v1", 512'(v1), 512'(0));
        chk("rst_v2", 512'(v2), 512'(0));
        chk("rst_d1", 512'(d1), 512'(0));
        chk("rst_d2", d2, 512'(0));
        #1 rst_n = 1'b1;

        // Nominal run: 1 + 8 + 1024 edges from start to done.
        do_clr();
        pulse_start();
        wait_done(2000, cyc);
        chk("nom_done_seen", 512'(ap_done), 512'(1));
        chk("nom_latency", 512'(cyc), 512'(1033));
        @(negedge clk);
        chk("nom_done_pulse", 512'(ap_done), 512'(0));
        chk("nom_idle_after", 512'(ap_idle), 512'(1));
        verify("nom", 1);
        w1 = (dataq.size() > 1) ? dataq[1] : '0;
        chk("nom_w1_l0", 512'(w1[31:0]), 512'(16));
        chk("nom_w1_l15", 512'(w1[511:480]), 512'(31));

        // Random backpressure on both ports
        mode = 1;
        do_clr();
        pulse_start();
        wait_done(10000, cyc);
        chk("bp_done_seen", 512'(ap_done), 512'(1));
        @(negedge clk);
        verify("bp", 1);

        // Config sink never ready
        mode = 2;
        do_clr();
        pulse_start();
        repeat (200) @(negedge clk);
        chk("stall_v1", 512'(v1), 512'(1));
        chk("stall_d1", 512'(d1), 512'({TAG, 32'h0}));
        chk("stall_v2", 512'(v2), 512'(0));
        chk("stall_idle", 512'(ap_idle), 512'(0));
        chk("stall_dones", 512'(done_cnt), 512'(0));
        chk("stall_ncfg", 512'(cfgq.size()), 512'(0));
        chk("stall_stable", 512'(viol), 512'(0));
        #1 rst_n = 1'b0;
        mode = 0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // ap_start held high: two back-to-back runs
        do_clr();
        @(posedge clk);
        #1 start = 1'b1;
        nd  = 0;
        cyc = 0;
        while (nd < 2 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (ap_done) nd++;
        end
        start = 1'b0;
        chk("b2b_two_dones", 512'(nd), 512'(2));
        repeat (5) @(negedge clk);
        chk("b2b_idle", 512'(ap_idle), 512'(1));
        verify("b2b", 2);

        // Reset in the middle of the data stream
        do_clr();
        pulse_start();
        cyc = 0;
        while (cyc < 500) begin
            @(negedge clk);
            #1;
            cyc++;
            if (dataq.size() > 100) break;
        end
        chk("mid_reached", 512'(dataq.size() > 100), 512'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_v1", 512'(v1), 512'(0));
        chk("mid_v2", 512'(v2), 512'(0));
        chk("mid_d1", 512'(d1), 512'(0));
        chk("mid_d2", d2, 512'(0));
        chk("mid_idle", 512'(ap_idle), 512'(1));
        chk("mid_done", 512'(ap_done), 512'(0));
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        do_clr();
        pulse_start();
        wait_done(2000, cyc);
        chk("re_done_seen", 512'(ap_done), 512'(1));
        @(negedge clk);
        verify("re", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bft_data_gen_config.md
Name: bft_data_gen_config

Overview:
- Single-clock, HLS-style (ap_ctrl_hs) stimulus source for the BFT/rendering fabric.
- On each ap_start it streams a fixed BFT configuration sequence on a 64-bit AXI-Stream port.
- It then streams a fixed 512-bit data sequence on a second AXI-Stream port, and signals completion.
- Sits in front of the fabric's config FIFO and data-in FIFO; one or more instances may be muxed onto one fabric.

Parameters:
- NUM_CFG, 8, number of 64-bit configuration words per run (1..65535)
- NUM_DATA, 1024, number of 512-bit data words per run (1..2^24-1)
- CFG_TAG, 32'hBFC0_0000, constant upper half of every config word

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- ap_start  in  1  start request
- ap_done  out  1  one-cycle completion pulse
- ap_idle  out  1  high while no run in progress
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- Output_1_TDATA  out  64  config word
- Output_1_TVALID  out  1  config word valid
- Output_1_TREADY  in  1  config sink ready
- Output_2_TDATA  out  512  data word
- Output_2_TVALID  out  1  data word valid
- Output_2_TREADY  in  1  data sink ready

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; both TVALID=0; both TDATA=0; all counters=0.
  - ap_idle=1; ap_done=0; ap_ready=0.
- FSM states: IDLE, CFG, DATA, DONE.
- IDLE:
  - ap_idle=1.
  - ap_start sampled high at a rising edge → CFG next cycle, Output_1_TVALID=1, TDATA=word 0.
  - A single-cycle pulse is sufficient.
- CFG:
  - Config word k = {CFG_TAG, 32'(k)}, k=0..NUM_CFG-1.
  - Handshake = TVALID & TREADY at a rising edge.
  - On handshake of word k<NUM_CFG-1: present word k+1 next cycle. Throughput is 1 word/cycle when TREADY is held high.
  - On handshake of the last word: Output_1_TVALID=0 and state→DATA. Output_2_TVALID=1 with data word 0 in the same next cycle.
- DATA:
  - Data word n consists of 16 x 32-bit lanes; lane j (bits 32j+31:32j) = 16*n + j.
  - Handshake and advance rules are identical to CFG.
  - On the last handshake: Output_2_TVALID=0, state→DONE.
- DONE: ap_done=1 and ap_ready=1 for exactly one cycle, then IDLE (ap_idle=1 again).
- ap_idle=0 in CFG, DATA and DONE.
- ap_start is ignored outside IDLE.
- If ap_start is high in IDLE immediately after DONE, a new run begins; counters restart at 0.
- Backpressure:
  - While TVALID=1 and TREADY=0, TDATA and TVALID hold stable indefinitely.
  - TVALID never depends combinationally on TREADY.
  - TREADY held 0 forever stalls the block with no loss or duplication.
- The two streams are never valid simultaneously.
- All outputs are registered.
- Reset mid-run: immediate abort to reset values. The next run restarts at config word 0.

Decomposition:
- Package bft_gen_pkg holds:
  - CFG_W=64, DATA_W=512, LANE_W=32, LANES=16
  - CFG_TAG default
  - the state enum {IDLE, CFG, DATA, DONE}
- One natural sub-module: axis_seq_src.
  - Parameterised width and count; holds a registered valid/data word and an index counter.
  - Provides start/last/done hooks.
  - Instantiated twice, once per stream, with the FSM sequencing them.

Test Plan:
- Reset: hold ap_rst_n=0 for 10 cycles → ap_idle=1, both TVALID=0, ap_done=0, both TDATA=0.
- Nominal run, both TREADY=1, ap_start 1-cycle pulse:
  - config words 0xBFC00000_00000000..0xBFC00000_00000007 on 8 consecutive cycles;
  - then 1024 data words, word 1 lane 0 = 16, lane 15 = 31;
  - then ap_done=ap_ready=1 for one cycle, then ap_idle=1.
  - An external handshake counter reads 8 and 1024.
- Backpressure: random TREADY toggling on both ports → identical sequences and counts; data stable while valid & !ready.
- TREADY=0 permanently on Output_1 → Output_1_TVALID stays 1 with word 0; Output_2_TVALID never asserts; ap_done never pulses.
- ap_start held high continuously → back-to-back runs, each restarting at k=0/n=0, one ap_done per run.
- Reset asserted mid-DATA (after word 100) → outputs return to reset values immediately; next ap_start emits config word 0 first.
